ws2812b_rx: RTL

Receive-side decoder for the one-wire WS2812B NRZ protocol used by the LED chain transmitter. Samples a serial line, measures high-pulse widths to recover bits, assembles 24-bit GRB pixel words MSB-first, and detects the latch/reset gap that ends a frame. It sits on a spare input pin, fed from the chain data output (_48b) in loopback. It checks Game-of-Life frames in hardware and drives a frame/pixel stream into debug logic.

---
 rtl/ws2812b_rx.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ws2812b_rx.sv
// ws2812b_rx - receive-side decoder for the one-wire WS2812B NRZ protocol.
// Synchronizes the raw line and measures each high pulse to decide a 0 or a 1.
// Bits are assembled MSB-first into 24-bit GRB pixels. A long low gap marks the
// latch that ends a frame. Every output is registered.
module ws2812b_rx #(
    parameter int THRESH_CYCLES   = 7,
    parameter int MIN_HIGH_CYCLES = 2,
    parameter int MAX_HIGH_CYCLES = 30,
    parameter int RESET_CYCLES    = 600,
    parameter int IDX_W           = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic [IDX_W:0]   frame_pixels,
    output logic             error,
    output logic             synced
);

    localparam int LCNT_W = $clog2(RESET_CYCLES + 1);
    localparam int HCNT_W = $clog2(MAX_HIGH_CYCLES + 1);

    localparam logic [LCNT_W-1:0] LOW_LIMIT  = LCNT_W'(RESET_CYCLES);
    localparam logic [LCNT_W-1:0] LOW_ZERO   = {LCNT_W{1'b0}};
    localparam logic [LCNT_W-1:0] LOW_ONE    = LCNT_W'(1);
    localparam logic [HCNT_W-1:0] HIGH_LIMIT = HCNT_W'(MAX_HIGH_CYCLES);
    localparam logic [HCNT_W-1:0] HIGH_MIN   = HCNT_W'(MIN_HIGH_CYCLES);
    localparam logic [HCNT_W-1:0] HIGH_ONE   = HCNT_W'(THRESH_CYCLES);
    localparam logic [HCNT_W-1:0] HIGH_ZERO  = {HCNT_W{1'b0}};
    localparam logic [HCNT_W-1:0] HIGH_START = HCNT_W'(1);
    localparam logic [IDX_W:0]    PIX_LIMIT  = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0]    PIX_ZERO   = {(IDX_W+1){1'b0}};
    localparam logic [IDX_W:0]    PIX_ONE    = {{IDX_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    // Synchronizer.
    logic [1:0]        sync_q, sync_d;
    logic              din_s;

    // Control state and counters.
    state_t            state_q, state_d;
    logic [LCNT_W-1:0] low_cnt_q, low_cnt_d;
    logic              latched_q, latched_d;
    logic [HCNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [IDX_W:0]    pix_cnt_q, pix_cnt_d;
    logic [22:0]       shreg_q, shreg_d;

    // Output registers.
    logic [23:0]       pixel_data_q, pixel_data_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic [IDX_W-1:0]  pixel_index_q, pixel_index_d;
    logic              frame_done_q, frame_done_d;
    logic [IDX_W:0]    frame_pixels_q, frame_pixels_d;
    logic              error_q, error_d;
    logic              synced_q, synced_d;

    // Line events decoded in the next-state process.
    logic              sync_done_s;
    logic              rise_s;
    logic              latch_s;
    logic              overlong_s;
    logic              glitch_s;
    logic              bit_end_s;
    logic              bit_val_s;
    logic [HCNT_W-1:0] high_inc_s;

    assign din_s = sync_q[1];

    // Shift the raw line through two stages before anything looks at it.
    always_comb begin
        sync_d = {sync_q[0], din};
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: classify the current sample and pick the successor state.
    always_comb begin
        state_d     = state_q;
        sync_done_s = 1'b0;
        rise_s      = 1'b0;
        latch_s     = 1'b0;
        overlong_s  = 1'b0;
        glitch_s    = 1'b0;
        bit_end_s   = 1'b0;
        high_inc_s  = high_cnt_q + HIGH_START;
        case (state_q)
            ST_SYNC: begin
                if (!din_s && (low_cnt_q == LOW_LIMIT)) begin
                    sync_done_s = 1'b1;
                    state_d     = ST_LOW;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_LOW: begin
                // The latch is taken from the registered count, and only once per gap.
                latch_s = (low_cnt_q == LOW_LIMIT) && !latched_q;
                if (din_s) begin
                    rise_s  = 1'b1;
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (din_s) begin
                    if (high_inc_s == HIGH_LIMIT) begin
                        overlong_s = 1'b1;
                        state_d    = ST_SYNC;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else if (high_cnt_q < HIGH_MIN) begin
                    glitch_s = 1'b1;
                    state_d  = ST_LOW;
                end else begin
                    bit_end_s = 1'b1;
                    state_d   = ST_LOW;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Output and datapath logic: counters, shift register and the registered pulses.
    always_comb begin
        low_cnt_d      = low_cnt_q;
        latched_d      = latched_q;
        high_cnt_d     = high_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        shreg_d        = shreg_q;
        pixel_data_d   = pixel_data_q;
        pixel_index_d  = pixel_index_q;
        frame_pixels_d = frame_pixels_q;
        pixel_valid_d  = 1'b0;
        frame_done_d   = 1'b0;
        error_d        = 1'b0;
        bit_val_s      = (high_cnt_q >= HIGH_ONE);
        case (state_q)
            ST_SYNC: begin
                // Hunt for a full low gap; any high restarts the hunt.
                if (din_s) begin
                    low_cnt_d = LOW_ZERO;
                end else if (sync_done_s) begin
                    low_cnt_d = LOW_ZERO;
                    latched_d = 1'b0;
                end else begin
                    low_cnt_d = low_cnt_q + LOW_ONE;
                end
            end
            ST_LOW: begin
                if (latch_s) begin
                    latched_d = 1'b1;
                    bit_cnt_d = 5'd0;
                    pix_cnt_d = PIX_ZERO;
                    error_d   = (bit_cnt_q != 5'd0);
                    if (pix_cnt_q != PIX_ZERO) begin
                        frame_done_d   = 1'b1;
                        frame_pixels_d = pix_cnt_q;
                    end else begin
                        frame_done_d = 1'b0;
                    end
                end else begin
                    latched_d = latched_q;
                end
                // The low count freezes while high so a glitch can resume it.
                if (rise_s) begin
                    high_cnt_d = HIGH_START;
                end else if (low_cnt_q != LOW_LIMIT) begin
                    low_cnt_d = low_cnt_q + LOW_ONE;
                end else begin
                    low_cnt_d = low_cnt_q;
                end
            end
            ST_HIGH: begin
                if (overlong_s) begin
                    error_d    = 1'b1;
                    bit_cnt_d  = 5'd0;
                    pix_cnt_d  = PIX_ZERO;
                    low_cnt_d  = LOW_ZERO;
                    latched_d  = 1'b0;
                    high_cnt_d = HIGH_ZERO;
                end else if (din_s) begin
                    high_cnt_d = high_inc_s;
                end else if (glitch_s) begin
                    high_cnt_d = HIGH_ZERO;
                end else if (bit_end_s) begin
                    high_cnt_d = HIGH_ZERO;
                    low_cnt_d  = LOW_ONE;
                    latched_d  = 1'b0;
                    shreg_d    = {shreg_q[21:0], bit_val_s};
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = 5'd0;
                        if (pix_cnt_q == PIX_LIMIT) begin
                            // Frame already full: report it and drop the pixel.
                            error_d = 1'b1;
                        end else begin
                            pixel_data_d  = {shreg_q, bit_val_s};
                            pixel_index_d = pix_cnt_q[IDX_W-1:0];
                            pixel_valid_d = 1'b1;
                            pix_cnt_d     = pix_cnt_q + PIX_ONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    high_cnt_d = high_cnt_q;
                end
            end
            default: begin
                low_cnt_d = LOW_ZERO;
            end
        endcase
        synced_d = (state_d != ST_SYNC);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_q      <= LOW_ZERO;
            latched_q      <= 1'b0;
            high_cnt_q     <= HIGH_ZERO;
            bit_cnt_q      <= 5'd0;
            pix_cnt_q      <= PIX_ZERO;
            shreg_q        <= 23'd0;
            pixel_data_q   <= 24'd0;
            pixel_valid_q  <= 1'b0;
            pixel_index_q  <= {IDX_W{1'b0}};
            frame_done_q   <= 1'b0;
            frame_pixels_q <= PIX_ZERO;
            error_q        <= 1'b0;
            synced_q       <= 1'b0;
        end else begin
            low_cnt_q      <= low_cnt_d;
            latched_q      <= latched_d;
            high_cnt_q     <= high_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            shreg_q        <= shreg_d;
            pixel_data_q   <= pixel_data_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_index_q  <= pixel_index_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            error_q        <= error_d;
            synced_q       <= synced_d;
        end
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign pixel_index  = pixel_index_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign error        = error_q;
    assign synced       = synced_q;

endmodule
